fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the first fetch address after reset; bit 0 is forced to 0.
REQ-002 Parameter BUF_DEPTH, default 2, is the instruction buffer entries; legal values are 2 and 4.
REQ-003 clk  input  1  is the single clock; every flop samples on its rising edge.
REQ-004 rst_n  input  1  is the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 stall_in  input  8  is the stall vector from the pipeline controller; any set bit blocks consumption.
REQ-006 branch_valid  input  1  is the redirect request from execute.
REQ-007 branch_target  input  16  is the redirect address.
REQ-008 imem_req  output  1  is the instruction memory read request.
REQ-009 imem_addr  output  16  is the read address, always word-aligned.
REQ-010 imem_ack  input  1  is the read completion; imem_rdata is valid in the same cycle.
REQ-011 imem_rdata  input  16  is the instruction word.
REQ-012 instr_o  output  16  is the buffer head instruction and drives fetch_in of the pipeline registers.
REQ-013 instr_pc_o  output  16  is the address of instr_o.
REQ-014 instr_valid_o  output  1  is high when the buffer is non-empty.
REQ-015 clear_o  output  1  is a one-cycle pipeline clear pulse and drives clear_in.
REQ-016 pc_o  output  16  is the next address to request.

Function
REQ-017 FSM states: IDLE (no request), REQ (request held), DROP (outstanding request being discarded).
REQ-018 IDLE->REQ when count + outstanding < BUF_DEPTH and branch_valid=0.
REQ-019 In REQ, imem_req=1 and imem_addr=pc_o, both held stable until the cycle imem_ack=1.
REQ-020 On ack in REQ: push {imem_rdata, imem_addr}, pc_o += 2 (16-bit wrap, FFFE->0000), stay in REQ if space remains, else go to IDLE.
REQ-021 Consume (pop) when instr_valid_o=1 and stall_in==8'h00.
REQ-022 Simultaneous push and pop on a full buffer is legal; count is unchanged.
REQ-023 No push occurs when full; the REQ entry condition guarantees this.
REQ-024 When empty: instr_valid_o=0, instr_o=16'h0000, instr_pc_o holds its last value.
REQ-025 branch_valid=1 has priority over push and pop in the same cycle.
REQ-026 On branch: flush the buffer (count=0), pc_o={branch_target[15:1],1'b0}, clear_o=1 in the next cycle only.
REQ-027 On branch while in REQ without ack that cycle: go to DROP and deassert imem_req; data from the next ack is discarded; then go to REQ at the new pc_o.
REQ-028 On branch with ack in the same cycle: the acked word is discarded and the state goes to REQ at the target.
REQ-029 A branch while already in DROP retargets pc_o and stays in DROP.
REQ-030 Back-to-back branch cycles each produce clear_o, so clear_o may stay high for several cycles.
REQ-031 Minimum fetch latency: ack in cycle N gives instr_valid_o=1 in cycle N+1.

Reset
REQ-032 While rst_n=0:
- state=IDLE, count=0, no outstanding request
- pc_o=RESET_PC, imem_req=0, imem_addr=RESET_PC
- instr_o=0, instr_pc_o=0, instr_valid_o=0, clear_o=0
REQ-033 Reset asserted mid-request abandons the request; an ack during reset is ignored.
REQ-034 The first imem_req is driven in the first cycle after rst_n=1.

Configuration
REQ-035 Macro FETCH_BYPASS_EN, when defined: if the buffer is empty and an ack arrives, instr_o/instr_pc_o/instr_valid_o present imem_rdata combinationally in the same cycle.
- If it is consumed that cycle, nothing is pushed.
REQ-036 Without FETCH_BYPASS_EN, all outputs are registered and REQ-031 latency applies.

Verification
REQ-037 Reset release with ack always high, stall_in=0 -> instr_pc_o sequence 0000,0002,0004; one instruction per cycle after the first.
REQ-038 stall_in=8'h04 held 5 cycles with BUF_DEPTH=2 -> count reaches 2, imem_req falls, instr_o constant; release -> pops resume in order.
REQ-039 branch_valid with target 16'h0121 while REQ is outstanding -> clear_o=1 for one cycle, pc_o=0120, stale ack data never appears on instr_o, next instr_pc_o=0120.
REQ-040 Branch and ack in the same cycle -> acked word dropped, next request address = target.
REQ-041 pc_o=FFFE fetch -> next imem_addr=0000.
REQ-042 With FETCH_BYPASS_EN, buffer empty and ack with rdata=16'hA5A5 -> instr_valid_o=1 and instr_o=A5A5 in the ack cycle; without the macro -> one cycle later.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: drives a single-outstanding imem request and queues {instr, pc} in a small buffer.
// Optional macro FETCH_BYPASS_EN forwards an ack straight to the outputs when the buffer is empty.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  stall_in,
  input  logic        branch_valid,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr_o,
  output logic [15:0] instr_pc_o,
  output logic        instr_valid_o,
  output logic        clear_o,
  output logic [15:0] pc_o
);

  localparam int          PW       = $clog2(BUF_DEPTH);
  localparam int          CW       = PW + 1;
  localparam logic [15:0] RESET_PC_A = RESET_PC & 16'hFFFE;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t          state_q, state_d;
  logic [15:0]     pc_q, pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [15:0]     last_pc_q, last_pc_d;
  logic            clear_q, clear_d;
  logic [15:0]     instr_buf_q [BUF_DEPTH];
  logic [15:0]     pc_buf_q    [BUF_DEPTH];

  logic ack_req, bypass_vld, buf_vld, pop, pop_buf, push;

  always_comb begin
    ack_req = (state_q == REQ) && imem_ack;
    buf_vld = (count_q != '0);
`ifdef FETCH_BYPASS_EN
    bypass_vld = ack_req && !buf_vld && !branch_valid;
`else
    bypass_vld = 1'b0;
`endif
    instr_valid_o = buf_vld || bypass_vld;
    if (buf_vld) begin
      instr_o    = instr_buf_q[rd_q];
      instr_pc_o = pc_buf_q[rd_q];
    end else if (bypass_vld) begin
      instr_o    = imem_rdata;
      instr_pc_o = pc_q;
    end else begin
      instr_o    = 16'h0000;
      instr_pc_o = last_pc_q;
    end
    // Branch wins over both ends of the buffer; a bypassed word that is consumed never enters it.
    pop     = instr_valid_o && (stall_in == 8'h00) && !branch_valid;
    pop_buf = pop && buf_vld;
    push    = ack_req && !branch_valid && !(bypass_vld && pop);
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q + CW'(push) - CW'(pop_buf);
    rd_d      = pop_buf ? rd_q + PW'(1) : rd_q;
    wr_d      = push ? wr_q + PW'(1) : wr_q;
    last_pc_d = instr_pc_o;
    clear_d   = branch_valid;
    if (branch_valid) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
      pc_d    = branch_target & 16'hFFFE;
      case (state_q)
        REQ:     state_d = imem_ack ? REQ : DROP;
        DROP:    state_d = imem_ack ? REQ : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: if (count_q < CW'(BUF_DEPTH)) state_d = REQ;
        REQ: if (imem_ack) begin
          pc_d    = pc_q + 16'd2;
          state_d = (count_d < CW'(BUF_DEPTH)) ? REQ : IDLE;
        end
        DROP: if (imem_ack) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC_A;
      count_q   <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      last_pc_q <= 16'h0000;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      last_pc_q <= last_pc_d;
      clear_q   <= clear_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      instr_buf_q[wr_q] <= imem_rdata;
      pc_buf_q[wr_q]    <= pc_q;
    end
  end

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;
  assign pc_o      = pc_q;
  assign clear_o   = clear_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized plus directed bench for fetch_stage, checked every cycle against a queue-based model.
module tb_fetch_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  stall_in;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr_o, instr_pc_o, pc_o;
  logic        instr_valid_o, clear_o;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mq[$];
  logic [15:0] m_pc, m_last;
  bit          m_req, m_drop, m_clr;

  fetch_stage #(.RESET_PC(16'h0000), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_valid_o(instr_valid_o), .clear_o(clear_o), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = 16'h0000; m_last = 16'h0000;
    m_req = 0; m_drop = 0; m_clr = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle, advance the model on the edge.
  task automatic cyc(input bit ack, input logic [7:0] st, input bit br,
                     input logic [15:0] tgt, input logic [15:0] rd);
    bit          bp, e_vld, pop, idle_go;
    logic [15:0] e_instr, e_ipc;
    imem_ack = ack; stall_in = st; branch_valid = br;
    branch_target = tgt; imem_rdata = rd;
    bp = 0;
`ifdef FETCH_BYPASS_EN
    bp = m_req && ack && (mq.size() == 0) && !br;
`endif
    e_vld   = (mq.size() > 0) || bp;
    e_instr = (mq.size() > 0) ? mq[0][31:16] : (bp ? rd : 16'h0000);
    e_ipc   = (mq.size() > 0) ? mq[0][15:0]  : (bp ? m_pc : m_last);
    @(negedge clk);
    check("instr_valid", {15'd0, instr_valid_o}, {15'd0, e_vld});
    check("instr",       instr_o,    e_instr);
    check("instr_pc",    instr_pc_o, e_ipc);
    check("imem_req",    {15'd0, imem_req}, {15'd0, m_req});
    check("imem_addr",   imem_addr,  m_pc);
    check("pc_o",        pc_o,       m_pc);
    check("clear",       {15'd0, clear_o}, {15'd0, m_clr});
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      pop    = e_vld && (st == 8'h00) && !br;
      m_last = e_ipc;
      m_clr  = br;
      if (br) begin
        mq.delete();
        m_pc = tgt & 16'hFFFE;
        if (m_req && !ack) begin m_req = 0; m_drop = 1; end
        else if (m_drop && ack) begin m_drop = 0; m_req = 1; end
      end else begin
        idle_go = !m_req && !m_drop && (mq.size() < DEPTH);
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (m_req && ack) begin
          if (!(bp && pop)) mq.push_back({rd, m_pc});
          m_pc  = m_pc + 16'd2;
          m_req = (mq.size() < DEPTH);
        end else if (m_drop && ack) begin
          m_drop = 0; m_req = 1;
        end else if (idle_go) begin
          m_req = 1;
        end
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ack = 1'b0; stall_in = 8'h00; branch_valid = 1'b0;
    branch_target = 16'h0000; imem_rdata = 16'h0000;
    model_reset();
    @(posedge clk); #1;
    // Reset with ack asserted must be ignored.
    repeat (3) cyc(1, 8'h00, 0, 16'h0000, 16'h7777);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cyc(1, 8'h00, 0, 16'h0000, 16'h1000 + 16'(i));
    // Stall fills the buffer and drops the request.
    for (int i = 0; i < 5; i++) cyc(1, 8'h04, 0, 16'h0000, 16'h2000 + 16'(i));
    for (int i = 0; i < 4; i++) cyc(1, 8'h00, 0, 16'h0000, 16'h2100 + 16'(i));
    // Branch with request outstanding, stale ack carries DEAD.
    cyc(0, 8'h00, 1, 16'h0121, 16'h0000);
    cyc(1, 8'h00, 0, 16'h0000, 16'hDEAD);
    for (int i = 0; i < 4; i++) cyc(1, 8'h00, 0, 16'h0000, 16'h3000 + 16'(i));
    // Branch and ack in the same cycle.
    cyc(1, 8'h00, 1, 16'h0300, 16'hBEEF);
    for (int i = 0; i < 3; i++) cyc(1, 8'h00, 0, 16'h0000, 16'h4000 + 16'(i));
    // Address wrap at FFFE.
    cyc(0, 8'h00, 1, 16'hFFFE, 16'h0000);
    for (int i = 0; i < 5; i++) cyc(1, 8'h00, 0, 16'h0000, 16'h5000 + 16'(i));
    // Back-to-back branches keep clear high.
    cyc(0, 8'h00, 1, 16'h0040, 16'h0000);
    cyc(0, 8'h00, 1, 16'h0080, 16'h0000);
    for (int i = 0; i < 3; i++) cyc(1, 8'h00, 0, 16'h0000, 16'h6000 + 16'(i));
    // Reset in the middle of a request.
    rst_n = 1'b0;
    repeat (2) cyc(1, 8'h00, 0, 16'h0000, 16'h6666);
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) != 0),
          ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
          ($urandom_range(0, 15) == 0),
          16'($urandom), 16'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
